dds_sweep_ctrl: RTL and testbench

- Linear frequency-sweep (chirp) sequencer that sits directly upstream of the DDS core.
- Drives the core's fword and pword inputs.
- Steps fword from a start word to a stop word in fixed increments, holding each word for a programmable dwell.
- Supports single-shot and continuous sweeps, with start/abort control and done/step status.

---
 rtl/dds_sweep_pkg.sv | 13 +
 rtl/dds_dwell_timer.sv | 27 ++
 rtl/dds_sweep_ctrl.sv | 146 ++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_sweep_pkg.sv
// Shared encodings for the DDS chirp sequencer: FSM states and sweep direction.
package dds_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic UP   = 1'b0;
    localparam logic DOWN = 1'b1;

endpackage

// File: rtl/dds_dwell_timer.sv
// Dwell timer: counts up while enabled and pulses expire when the count reaches the
// latched dwell, clearing itself so each word is held dwell+1 cycles.
module dds_dwell_timer #(
    parameter int DWELL_BITWIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      en,
    input  logic                      load,
    input  logic                      clr,
    input  logic [DWELL_BITWIDTH-1:0] dwell,
    output logic                      expire
);

    logic [DWELL_BITWIDTH-1:0] count;

    assign expire = en && (count == dwell);

    always_ff @(posedge clk) begin
        if (!rstn || load || clr) begin
            count <= '0;
        end else if (en) begin
            count <= expire ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear chirp sequencer driving DDS fword/pword. Defining DDS_SWEEP_TRIANGLE_EN turns
// continuous mode into a triangle sweep instead of a sawtooth reload.
//
// state | meaning
// IDLE  | waiting for start; fword holds last value
// RUN   | stepping fword, each word held dwell+1 cycles
// DONE  | one-cycle completion pulse of a single sweep
module dds_sweep_ctrl
    import dds_sweep_pkg::*;
#(
    parameter int DEPTH_BITWIDTH = 8,
    parameter int DWELL_BITWIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      continuous,
    input  logic [DEPTH_BITWIDTH-1:0] f_start,
    input  logic [DEPTH_BITWIDTH-1:0] f_stop,
    input  logic [DEPTH_BITWIDTH-1:0] f_step,
    input  logic [DWELL_BITWIDTH-1:0] dwell,
    input  logic [DEPTH_BITWIDTH-1:0] pword_in,
    output logic [DEPTH_BITWIDTH-1:0] fword,
    output logic [DEPTH_BITWIDTH-1:0] pword,
    output logic                      busy,
    output logic                      step_strobe,
    output logic                      done
);

    localparam int W = DEPTH_BITWIDTH;

    state_t                    state;
    logic [W-1:0]              start_l;
    logic [W-1:0]              stop_l;
    logic [W-1:0]              step_l;
    logic [DWELL_BITWIDTH-1:0] dwell_l;
    logic                      dir_l;
    logic                      cont_l;
    logic                      start_ok;
    logic                      expire;

    assign start_ok = (state == IDLE) && start && !abort;

    dds_dwell_timer #(
        .DWELL_BITWIDTH(DWELL_BITWIDTH)
    ) u_timer (
        .clk    (clk),
        .rstn   (rstn),
        .en     ((state == RUN) && !abort),
        .load   (start_ok),
        .clr    (abort),
        .dwell  (dwell_l),
        .expire (expire)
    );

    // One extra bit catches overflow/underflow so the result clamps exactly to the target.
    function automatic logic [W-1:0] next_word(input logic [W-1:0] cur,
                                               input logic [W-1:0] step,
                                               input logic [W-1:0] target,
                                               input logic         dir);
        logic [W:0] sum;
        logic [W:0] diff;
        sum  = {1'b0, cur} + {1'b0, step};
        diff = {1'b0, cur} - {1'b0, step};
        if (dir == UP) begin
            next_word = (sum > {1'b0, target}) ? target : sum[W-1:0];
        end else begin
            next_word = (diff[W] || (diff[W-1:0] < target)) ? target : diff[W-1:0];
        end
    endfunction

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            fword       <= '0;
            pword       <= '0;
            busy        <= 1'b0;
            step_strobe <= 1'b0;
            done        <= 1'b0;
            start_l     <= '0;
            stop_l      <= '0;
            step_l      <= '0;
            dwell_l     <= '0;
            dir_l       <= UP;
            cont_l      <= 1'b0;
        end else begin
            pword       <= pword_in;
            step_strobe <= 1'b0;
            done        <= 1'b0;
            if (abort) begin
                state <= IDLE;
                fword <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            start_l <= f_start;
                            stop_l  <= f_stop;
                            step_l  <= (f_step == '0) ? W'(1) : f_step;
                            dwell_l <= dwell;
                            dir_l   <= (f_stop < f_start) ? DOWN : UP;
                            cont_l  <= continuous;
                            fword   <= f_start;
                            busy    <= 1'b1;
                            state   <= RUN;
                        end
                    end
                    RUN: begin
                        if (expire) begin
                            if (fword == stop_l) begin
                                if (!cont_l) begin
                                    state <= DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end else begin
`ifdef DDS_SWEEP_TRIANGLE_EN
                                    // Turn around immediately so the end word is not repeated.
                                    start_l <= stop_l;
                                    stop_l  <= start_l;
                                    dir_l   <= ~dir_l;
                                    fword   <= next_word(fword, step_l, start_l, ~dir_l);
`else
                                    fword   <= start_l;
`endif
                                    step_strobe <= 1'b1;
                                end
                            end else begin
                                fword       <= next_word(fword, step_l, stop_l, dir_l);
                                step_strobe <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: a word-list reference model expands each
// sweep into an expected per-cycle trace of fword/busy/step_strobe/done.
module tb_dds_sweep_ctrl;

    localparam int W  = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          continuous = 1'b0;
    logic [W-1:0]  f_start = '0;
    logic [W-1:0]  f_stop = '0;
    logic [W-1:0]  f_step = '0;
    logic [DW-1:0] dwell = '0;
    logic [W-1:0]  pword_in = '0;
    logic [W-1:0]  fword;
    logic [W-1:0]  pword;
    logic          busy;
    logic          step_strobe;
    logic          done;

    int checks = 0;
    int errors = 0;

    int exp_words[$];
    int tf[$];
    bit tbusy[$];
    bit tstrb[$];
    bit tdone[$];

    dds_sweep_ctrl #(
        .DEPTH_BITWIDTH(W),
        .DWELL_BITWIDTH(DW)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .abort       (abort),
        .continuous  (continuous),
        .f_start     (f_start),
        .f_stop      (f_stop),
        .f_step      (f_step),
        .dwell       (dwell),
        .pword_in    (pword_in),
        .fword       (fword),
        .pword       (pword),
        .busy        (busy),
        .step_strobe (step_strobe),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Words visited going from a to b in steps of s, clamped to b.
    function automatic void build_seg(int a, int b, int s);
        int w;
        int st;
        st = (s == 0) ? 1 : s;
        w  = a;
        exp_words.push_back(w);
        while (w != b) begin
            if (b >= a) w = (w + st > b) ? b : w + st;
            else        w = (w - st < b) ? b : w - st;
            exp_words.push_back(w);
        end
    endfunction

    function automatic void build_cont(int a, int b, int s, int n);
        int sz;
        int x;
        int y;
        int t;
        exp_words.delete();
        build_seg(a, b, s);
        x = a;
        y = b;
        while (exp_words.size() < n) begin
`ifdef DDS_SWEEP_TRIANGLE_EN
            sz = exp_words.size();
            build_seg(y, x, s);
            exp_words.delete(sz);
            t = x; x = y; y = t;
`else
            sz = exp_words.size();
            t  = sz;
            build_seg(x, y, s);
`endif
        end
    endfunction

    function automatic void build_trace(int dw, bit single, int stop);
        tf.delete(); tbusy.delete(); tstrb.delete(); tdone.delete();
        foreach (exp_words[i]) begin
            for (int k = 0; k <= dw; k++) begin
                tf.push_back(exp_words[i]);
                tbusy.push_back(1'b1);
                tstrb.push_back(k == 0 && i > 0);
                tdone.push_back(1'b0);
            end
        end
        if (single) begin
            tf.push_back(stop); tbusy.push_back(1'b0); tstrb.push_back(1'b0); tdone.push_back(1'b1);
            tf.push_back(stop); tbusy.push_back(1'b0); tstrb.push_back(1'b0); tdone.push_back(1'b0);
        end
    endfunction

    // Starts a sweep and checks the trace; stray starts mid-run and in DONE must be ignored.
    task automatic run_trace(input int fs, input int fe, input int st, input int dw,
                             input bit cont, input bit stray);
        @(negedge clk);
        f_start = W'(fs); f_stop = W'(fe); f_step = W'(st); dwell = DW'(dw);
        continuous = cont; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        f_start = W'($urandom); f_stop = W'($urandom); f_step = W'($urandom);
        dwell = DW'($urandom_range(0, 5)); continuous = ~cont;
        for (int i = 0; i < tf.size(); i++) begin
            if (i > 0) @(negedge clk);
            start = 1'b0;
            checks++;
            if (fword !== W'(tf[i])) begin
                errors++;
                $display("FAIL fword cyc %0d got %0d exp %0d", i + 1, fword, tf[i]);
            end
            checks++;
            if (busy !== tbusy[i]) begin
                errors++;
                $display("FAIL busy cyc %0d got %0b exp %0b", i + 1, busy, tbusy[i]);
            end
            checks++;
            if (step_strobe !== tstrb[i]) begin
                errors++;
                $display("FAIL step_strobe cyc %0d got %0b exp %0b", i + 1, step_strobe, tstrb[i]);
            end
            checks++;
            if (done !== tdone[i]) begin
                errors++;
                $display("FAIL done cyc %0d got %0b exp %0b", i + 1, done, tdone[i]);
            end
            if (stray && (i == tf.size() / 2 || (!cont && i == tf.size() - 2))) start = 1'b1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        start = 1'b1; pword_in = 8'hA5; f_start = 8'd33;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({fword, pword, busy, step_strobe, done} !== '0) begin
            errors++;
            $display("FAIL reset got fword=%0d pword=%0d busy=%0b strb=%0b done=%0b exp all 0",
                     fword, pword, busy, step_strobe, done);
        end
        start = 1'b0; pword_in = '0; rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || fword !== '0) begin
            errors++;
            $display("FAIL reset_release got busy=%0b fword=%0d exp 0 0", busy, fword);
        end
    endtask

    task automatic test_single(input int fs, input int fe, input int st, input int dw);
        exp_words.delete();
        build_seg(fs, fe, st);
        build_trace(dw, 1'b1, fe);
        run_trace(fs, fe, st, dw, 1'b0, 1'b1);
    endtask

    task automatic test_random_single();
        for (int n = 0; n < 6; n++) begin
            test_single($urandom_range(0, 255), $urandom_range(0, 255),
                        $urandom_range(0, 60), $urandom_range(0, 2));
        end
    endtask

    task automatic test_continuous_abort(input int fs, input int fe, input int st, input int dw);
        build_cont(fs, fe, st, 12);
        build_trace(dw, 1'b0, fe);
        run_trace(fs, fe, st, dw, 1'b1, 1'b1);
        abort = 1'b1; start = 1'b1; f_start = 8'd77; continuous = 1'b0;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (fword !== '0 || busy !== 1'b0 || done !== 1'b0 || step_strobe !== 1'b0) begin
                errors++;
                $display("FAIL abort cyc %0d got fword=%0d busy=%0b done=%0b strb=%0b exp 0 0 0 0",
                         i, fword, busy, done, step_strobe);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        f_start = 8'd10; f_stop = 8'd40; f_step = 8'd10; dwell = 16'd2; continuous = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if ({fword, pword, busy, step_strobe, done} !== '0) begin
            errors++;
            $display("FAIL reset_mid got fword=%0d busy=%0b strb=%0b done=%0b exp 0",
                     fword, busy, step_strobe, done);
        end
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || fword !== '0) begin
            errors++;
            $display("FAIL reset_mid_idle got busy=%0b fword=%0d exp 0 0", busy, fword);
        end
    endtask

    task automatic test_pword();
        logic [W-1:0] last;
        @(negedge clk);
        last = W'($urandom);
        pword_in = last;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (pword !== last) begin
                errors++;
                $display("FAIL pword cyc %0d got %0d exp %0d", i, pword, last);
            end
            last = W'($urandom);
            pword_in = last;
        end
    endtask

    initial begin
        test_reset();
        test_single(10, 40, 10, 2);
        test_single(0, 25, 10, 0);
        test_single(200, 180, 7, 0);
        test_single(5, 5, 0, 3);
        test_single(250, 255, 20, 1);
        test_single(3, 0, 200, 0);
        test_random_single();
        test_continuous_abort(0, 20, 10, 0);
        test_continuous_abort(50, 20, 12, 1);
        test_reset_mid();
        test_single(10, 40, 10, 2);
        test_pword();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
